// File: rtl/program_sequencer_pkg.sv
// Shared types for the program sequencer: ICU opcode set and sequencer states.
// The return stack is enabled by defining SEQ_CALL_STACK_EN.
package program_sequencer_pkg;

  localparam int PROG_OP_W = 4;

  typedef enum logic [PROG_OP_W-1:0] {
    NOPO = 4'h0,
    LD   = 4'h1,
    LDC  = 4'h2,
    AND  = 4'h3,
    ANDC = 4'h4,
    OR   = 4'h5,
    ORC  = 4'h6,
    XNOR = 4'h7,
    STO  = 4'h8,
    STOC = 4'h9,
    IEN  = 4'hA,
    OEN  = 4'hB,
    JMP  = 4'hC,
    RTN  = 4'hD,
    SKZ  = 4'hE,
    NOPF = 4'hF
  } instruction_t;

  typedef enum logic [2:0] {
    HALT,
    FETCH,
    LOAD,
    REQ,
    DROP
  } seq_state_t;

endpackage

// File: rtl/program_sequencer_return_stack.sv
// LIFO of return addresses; push when full and pop when empty are ignored.
// Only instantiated when SEQ_CALL_STACK_EN is defined.
module seq_return_stack #(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] data_i,
  output logic [PC_W-1:0] data_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STACK_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [PC_W-1:0]  mem_q [STACK_DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] top_idx;

  assign full_o  = (cnt_q == CNT_MAX);
  assign empty_o = (cnt_q == '0);
  assign top_idx = IDX_W'(cnt_q - CNT_ONE);
  assign data_o  = mem_q[top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !full_o) begin
      mem_q[IDX_W'(cnt_q)] <= data_i;
      cnt_q <= cnt_q + CNT_ONE;
    end else if (pop_i && !empty_o) begin
      cnt_q <= cnt_q - CNT_ONE;
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: owns the PC, fetches ROM words, runs a 4-phase req/ack with the ICU.
// Optional return stack under SEQ_CALL_STACK_EN.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  output logic                      prog_rd,
  output logic [PC_W-1:0]           prog_addr,
  input  logic [PROG_OP_W+PC_W-1:0] prog_data,
  output logic                      req_o,
  input  logic                      ack_i,
  output instruction_t              instruction,
  output logic [PC_W-1:0]           io_addr,
  input  logic                      jmp_i,
  input  logic                      rtn_i,
  input  logic                      flag_f_i,
  output logic                      halted,
  output logic                      stack_err
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  seq_state_t             state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d, pc_inc, ret_pc;
  instruction_t           instr_q, instr_d;
  logic [PC_W-1:0]        io_q, io_d;
  logic                   req_q, req_d;
  logic                   stop_q, stop_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s, adv;

  // ICU is self-timed; ack crosses into clk through a plain shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= (sync_q << 1) | SYNC_STAGES'(ack_i);
  end

  assign ack_s  = sync_q[SYNC_STAGES-1];
  assign adv    = (state_q == REQ) && ack_s;
  assign pc_inc = pc_q + PC_ONE;

`ifdef SEQ_CALL_STACK_EN
  logic            push, pop, full, empty, err_q;
  logic [PC_W-1:0] top;

  assign push = adv && jmp_i;
  assign pop  = adv && !jmp_i && rtn_i;

  seq_return_stack #(
    .PC_W       (PC_W),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .data_i (pc_inc),
    .data_o (top),
    .full_o (full),
    .empty_o(empty)
  );

  assign ret_pc = empty ? pc_inc : top;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_q | (push & full) | (pop & empty);
  end

  assign stack_err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = rtn_i ^ (STACK_DEPTH > 0);
  assign ret_pc     = pc_inc;
  assign stack_err  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    io_d    = io_q;
    req_d   = req_q;
    stop_d  = stop_q;
    prog_rd = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      HALT: begin
        halted = 1'b1;
        if (run && !ack_s) state_d = FETCH;
      end
      FETCH: begin
        prog_rd = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        instr_d = instruction_t'(prog_data[PC_W +: PROG_OP_W]);
        io_d    = prog_data[PC_W-1:0];
        req_d   = 1'b1;
        state_d = REQ;
      end
      REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          stop_d  = flag_f_i;
          state_d = DROP;
          if (jmp_i)      pc_d = io_q;
          else if (rtn_i) pc_d = ret_pc;
          else            pc_d = pc_inc;
        end
      end
      DROP: begin
        if (!ack_s) state_d = (stop_q || !run) ? HALT : FETCH;
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HALT;
      pc_q    <= '0;
      instr_q <= NOPO;
      io_q    <= '0;
      req_q   <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      io_q    <= io_d;
      req_q   <= req_d;
      stop_q  <= stop_d;
    end
  end

  assign prog_addr   = pc_q;
  assign req_o       = req_q;
  assign instruction = instr_q;
  assign io_addr     = io_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: behavioural ICU and ROM, PC model walking the program.
`timescale 1ns/1ps
module tb_program_sequencer;
  import program_sequencer_pkg::*;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         run = 1'b0;
  logic         prog_rd;
  logic [7:0]   prog_addr;
  logic [11:0]  prog_data = '0;
  logic         req_o;
  logic         ack_i = 1'b0;
  instruction_t instruction;
  logic [7:0]   io_addr;
  logic         jmp_i = 1'b0;
  logic         rtn_i = 1'b0;
  logic         flag_f_i = 1'b0;
  logic         halted;
  logic         stack_err;

  int checks = 0;
  int failures = 0;

  logic [11:0] rom [256];
  bit          icu_en = 1'b1;
  int          icu_hold = 0;
  int          icu_dly = 0;

  logic [7:0]  fetch_q[$];
  logic [11:0] req_log[$];
  int          fetch_t[$];
  int          cyc = 0;

  logic [7:0]  m_pc = '0;
  logic [7:0]  m_stk[$];
  bit          m_err = 1'b0;

  program_sequencer #(
    .PC_W(8), .STACK_DEPTH(DEPTH), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .prog_rd(prog_rd), .prog_addr(prog_addr), .prog_data(prog_data),
    .req_o(req_o), .ack_i(ack_i),
    .instruction(instruction), .io_addr(io_addr),
    .jmp_i(jmp_i), .rtn_i(rtn_i), .flag_f_i(flag_f_i),
    .halted(halted), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (prog_rd) prog_data <= rom[prog_addr];

  initial begin : monitor
    logic req_prev;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (prog_rd) begin
        fetch_q.push_back(prog_addr);
        fetch_t.push_back(cyc);
      end
      if (req_o && !req_prev) req_log.push_back({instruction, io_addr});
      req_prev = req_o;
    end
  end

  initial begin : icu
    forever begin
      @(negedge clk);
      if (icu_en && req_o && !ack_i) begin
        repeat ($urandom_range(0, icu_dly)) @(negedge clk);
        jmp_i    = (instruction == JMP);
        rtn_i    = (instruction == RTN) ||
                   (instruction == JMP && $urandom_range(0, 1) == 1);
        flag_f_i = (instruction == NOPF);
        ack_i    = 1'b1;
        for (int n = 0; n < 200 && req_o; n++) @(negedge clk);
        repeat (icu_hold) @(negedge clk);
        repeat ($urandom_range(0, icu_dly)) @(negedge clk);
        {ack_i, jmp_i, rtn_i, flag_f_i} = '0;
      end
    end
  end

  initial begin : watchdog
    #800us;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // Walks the program from m_pc as the spec describes; 1 when a NOPF ends it
  function automatic bit model_exec(input int max_steps,
                                    output logic [7:0] exp[$]);
    logic [11:0] w;
    logic [7:0]  nxt;
    exp = {};
    for (int i = 0; i < max_steps; i++) begin
      w   = rom[m_pc];
      nxt = m_pc + 8'd1;
      exp.push_back(m_pc);
      if (w[11:8] == JMP) begin
`ifdef SEQ_CALL_STACK_EN
        if (m_stk.size() < DEPTH) m_stk.push_back(nxt);
        else m_err = 1'b1;
`endif
        m_pc = w[7:0];
      end else if (w[11:8] == RTN) begin
`ifdef SEQ_CALL_STACK_EN
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin m_err = 1'b1; m_pc = nxt; end
`else
        m_pc = nxt;
`endif
      end else begin
        m_pc = nxt;
      end
      if (w[11:8] == NOPF) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int seq_diff(input logic [7:0] exp[$]);
    int bad = 0;
    if (fetch_q.size() != exp.size()) bad++;
    if (req_log.size() != exp.size()) bad++;
    for (int i = 0; i < exp.size(); i++) begin
      if (i < fetch_q.size() && fetch_q[i] !== exp[i]) bad++;
      if (i < req_log.size() && req_log[i] !== rom[exp[i]]) bad++;
    end
    return bad;
  endfunction

  task automatic clear_logs();
    fetch_q.delete();
    req_log.delete();
    fetch_t.delete();
  endtask

  task automatic run_prog(output bit ok);
    int n = 0;
    run = 1'b1;
    while (halted && n < 100) begin @(negedge clk); n++; end
    ok = !halted;
    while (!halted && n < 4000) begin @(negedge clk); n++; end
    run = 1'b0;
    ok = ok && halted;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL rst_halted got=%b want=1", halted); end
    checks++; if (req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%b want=0", req_o); end
    checks++; if (prog_rd !== 1'b0) begin failures++; $display("FAIL rst_rd got=%b want=0", prog_rd); end
    checks++; if (prog_addr !== 8'h00) begin failures++; $display("FAIL rst_pc got=%h want=00", prog_addr); end
    checks++; if (instruction !== NOPO) begin failures++; $display("FAIL rst_instr got=%h want=0", instruction); end
    checks++; if (io_addr !== 8'h00) begin failures++; $display("FAIL rst_io got=%h want=00", io_addr); end
    checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b want=0", stack_err); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (halted !== 1'b1 || prog_rd !== 1'b0) begin failures++; $display("FAIL rst_idle got=%b%b want=10", halted, prog_rd); end
  endtask

  task automatic test_sequence();
    logic [7:0] exp[$];
    bit ok, mok;
    int bad = 0;
    rom[8'h00] = {LD, 8'h05};
    rom[8'h01] = {STO, 8'h06};
    rom[8'h02] = {NOPO, 8'h00};
    rom[8'h03] = {JMP, 8'h40};
    rom[8'h40] = {NOPF, 8'h00};
    icu_dly = 0;
    clear_logs();
    mok = model_exec(32, exp);
    run_prog(ok);
    checks++; if (!ok || !mok) begin failures++; $display("FAIL seq_done got=%b want=1", ok); end
    checks++; if (seq_diff(exp) != 0) begin failures++; $display("FAIL seq_fetch got=%p want=%p", fetch_q, exp); end
    checks++; if (req_log.size() < 2 || req_log[0][7:0] !== 8'h05 || req_log[1][7:0] !== 8'h06) begin
      failures++; $display("FAIL seq_io got=%p want=005,006", req_log); end
    for (int i = 1; i < fetch_t.size(); i++)
      if (fetch_t[i] - fetch_t[i-1] != 8) bad++;
    checks++; if (bad != 0 || fetch_t.size() < 2) begin failures++; $display("FAIL seq_latency got=%0d want=0 (interval!=8)", bad); end
    checks++; if (prog_addr !== 8'h41) begin failures++; $display("FAIL seq_pc got=%h want=41", prog_addr); end
    icu_dly = 3;
  endtask

  task automatic test_wrap();
    logic [7:0] exp[$];
    logic [7:0] got;
    bit ok, mok;
    rom[8'h41] = {JMP, 8'hFF};
    rom[8'hFF] = {LD, 8'h12};
    clear_logs();
    mok = model_exec(32, exp);
    run_prog(ok);
    got = (fetch_q.size() > 2) ? fetch_q[2] : 8'hxx;
    checks++; if (!ok || !mok) begin failures++; $display("FAIL wrap_done got=%b want=1", ok); end
    checks++; if (got !== 8'h00) begin failures++; $display("FAIL wrap_pc got=%h want=00", got); end
    checks++; if (seq_diff(exp) != 0) begin failures++; $display("FAIL wrap_fetch got=%p want=%p", fetch_q, exp); end
  endtask

  task automatic test_nopf_resume();
    logic [7:0] exp[$];
    logic [7:0] got;
    bit ok, mok;
    rom[8'h41] = {JMP, 8'h07};
    rom[8'h07] = {NOPF, 8'h00};
    rom[8'h08] = {NOPF, 8'h00};
    clear_logs();
    mok = model_exec(32, exp);
    run_prog(ok);
    checks++; if (seq_diff(exp) != 0 || !ok || !mok) begin failures++; $display("FAIL nopf_fetch got=%p want=%p", fetch_q, exp); end
    repeat (5) @(negedge clk);
    checks++; if (halted !== 1'b1 || prog_addr !== 8'h08) begin failures++; $display("FAIL nopf_park got=%b/%h want=1/08", halted, prog_addr); end
    checks++; if (fetch_q.size() != exp.size()) begin failures++; $display("FAIL nopf_idle got=%0d want=%0d", fetch_q.size(), exp.size()); end
    clear_logs();
    mok = model_exec(32, exp);
    run_prog(ok);
    got = (fetch_q.size() > 0) ? fetch_q[0] : 8'hxx;
    checks++; if (got !== 8'h08 || !ok) begin failures++; $display("FAIL nopf_resume got=%h want=08", got); end
  endtask

  task automatic test_run_drop();
    logic [7:0] exp[$];
    bit mok;
    int n = 0;
    rom[8'h09] = {OR, 8'h33};
    rom[8'h0A] = {JMP, 8'h10};
    clear_logs();
    mok = model_exec(1, exp);
    run = 1'b1;
    while (!req_o && n < 50) begin @(negedge clk); n++; end
    run = 1'b0;
    while (!halted && n < 300) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    checks++; if (mok || seq_diff(exp) != 0 || n >= 300) begin failures++; $display("FAIL drop_fetch got=%p want=%p", fetch_q, exp); end
    checks++; if (halted !== 1'b1 || prog_addr !== m_pc) begin failures++; $display("FAIL drop_pc got=%b/%h want=1/%h", halted, prog_addr, m_pc); end
  endtask

  task automatic test_rtn();
    logic [7:0] exp[$];
    bit ok, mok;
    rom[8'h0A] = {JMP, 8'h10};
    rom[8'h10] = {RTN, 8'h00};
    rom[8'h11] = {NOPF, 8'h00};
    rom[8'h0B] = {NOPF, 8'h00};
    clear_logs();
    mok = model_exec(32, exp);
    run_prog(ok);
    checks++; if (seq_diff(exp) != 0 || !ok || !mok) begin failures++; $display("FAIL rtn_fetch got=%p want=%p", fetch_q, exp); end
    checks++; if (stack_err !== m_err) begin failures++; $display("FAIL rtn_err got=%b want=%b", stack_err, m_err); end
`ifndef SEQ_CALL_STACK_EN
    checks++; if (fetch_q.size() < 3 || fetch_q[2] !== 8'h11) begin failures++; $display("FAIL rtn_plain got=%p want=0a,10,11", fetch_q); end
`endif
  endtask

  task automatic test_ack_hold();
    logic [7:0] exp[$];
    logic [7:0] a;
    bit mok;
    int n = 0;
    int bad = 0;
    a = m_pc;
    rom[a] = {LD, 8'h21};
    rom[a + 8'd1] = {NOPF, 8'h00};
    icu_hold = 20;
    clear_logs();
    mok = model_exec(32, exp);
    run = 1'b1;
    while (!req_o && n < 50) begin @(negedge clk); n++; end
    while (req_o && n < 300) begin @(negedge clk); n++; end
    repeat (20) begin
      @(negedge clk);
      if (req_o || prog_rd) bad++;
    end
    checks++; if (bad != 0 || fetch_q.size() != 1) begin failures++; $display("FAIL hold_quiet got=%0d/%0d want=0/1", bad, fetch_q.size()); end
    while (!halted && n < 1000) begin @(negedge clk); n++; end
    run = 1'b0;
    icu_hold = 0;
    checks++; if (seq_diff(exp) != 0 || !mok || n >= 1000) begin failures++; $display("FAIL hold_fetch got=%p want=%p", fetch_q, exp); end
  endtask

  task automatic test_reset_mid_req();
    int n = 0;
    rom[m_pc] = {LD, 8'hA5};
    icu_en = 1'b0;
    run = 1'b1;
    while (!req_o && n < 50) begin @(negedge clk); n++; end
    checks++; if (req_o !== 1'b1 || io_addr !== 8'hA5) begin failures++; $display("FAIL mid_reach got=%b/%h want=1/a5", req_o, io_addr); end
    rst_n = 1'b0;
    #1;
    checks++; if (req_o !== 1'b0 || halted !== 1'b1) begin failures++; $display("FAIL mid_req got=%b/%b want=0/1", req_o, halted); end
    checks++; if (prog_addr !== 8'h00) begin failures++; $display("FAIL mid_pc got=%h want=00", prog_addr); end
    checks++; if (instruction !== NOPO || io_addr !== 8'h00) begin failures++; $display("FAIL mid_instr got=%h/%h want=0/00", instruction, io_addr); end
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    icu_en = 1'b1;
    @(negedge clk);
    m_pc = '0;
    m_stk.delete();
    m_err = 1'b0;
  endtask

`ifdef SEQ_CALL_STACK_EN
  task automatic test_stack();
    logic [7:0] exp[$];
    logic [7:0] want[$];
    bit ok, mok;
    want = '{8'h00, 8'h20, 8'h30, 8'h50, 8'h60, 8'h70, 8'h51, 8'h31, 8'h21, 8'h01};
    rom[8'h00] = {JMP, 8'h20};
    rom[8'h20] = {JMP, 8'h30};
    rom[8'h30] = {JMP, 8'h50};
    rom[8'h50] = {JMP, 8'h60};
    rom[8'h60] = {JMP, 8'h70};
    rom[8'h70] = {RTN, 8'h00};
    rom[8'h51] = {RTN, 8'h00};
    rom[8'h31] = {RTN, 8'h00};
    rom[8'h21] = {RTN, 8'h00};
    rom[8'h01] = {NOPF, 8'h00};
    clear_logs();
    mok = model_exec(32, exp);
    run_prog(ok);
    checks++; if (fetch_q != want || !ok) begin failures++; $display("FAIL stack_lifo got=%p want=%p", fetch_q, want); end
    checks++; if (seq_diff(exp) != 0 || !mok) begin failures++; $display("FAIL stack_model got=%p want=%p", fetch_q, exp); end
    checks++; if (stack_err !== 1'b1) begin failures++; $display("FAIL stack_err got=%b want=1", stack_err); end
  endtask
`endif

  task automatic test_random();
    logic [7:0] exp[$];
    logic [7:0] s_stk[$];
    logic [7:0] s_pc;
    logic [3:0] op;
    bit s_err, ok, mok;
    int r;
    for (int it = 0; it < 6; it++) begin
      s_pc = m_pc; s_stk = m_stk; s_err = m_err;
      mok = 1'b0;
      for (int t = 0; t < 50 && !mok; t++) begin
        m_pc = s_pc; m_stk = s_stk; m_err = s_err;
        for (int a = 0; a < 256; a++) begin
          r = $urandom_range(0, 99);
          if (r < 70) begin
            r = $urandom_range(0, 12);
            op = (r == 12) ? 4'hE : 4'(r);
          end else if (r < 85) op = JMP;
          else if (r < 93) op = RTN;
          else op = NOPF;
          rom[a] = {op, 8'($urandom_range(0, 255))};
        end
        mok = model_exec(30, exp);
      end
      if (!mok) begin
        m_pc = s_pc; m_stk = s_stk; m_err = s_err;
        rom[m_pc] = {NOPF, 8'h00};
        mok = model_exec(30, exp);
      end
      clear_logs();
      run_prog(ok);
      checks++; if (seq_diff(exp) != 0 || !ok) begin failures++; $display("FAIL rand_fetch%0d got=%p want=%p", it, fetch_q, exp); end
      checks++; if (prog_addr !== m_pc || stack_err !== m_err) begin
        failures++; $display("FAIL rand_state%0d got=%h/%b want=%h/%b", it, prog_addr, stack_err, m_pc, m_err); end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = {NOPF, 8'h00};
    test_reset();
    test_sequence();
    test_wrap();
    test_nopf_resume();
    test_run_drop();
    test_rtn();
    test_ack_hold();
    test_reset_mid_req();
`ifdef SEQ_CALL_STACK_EN
    test_stack();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
